arb_merge_n_cache: RTL and testbench

ARB_MERGE_N_CACHE -- requirements
Module: arb_merge_n_cache

---
 rtl/arb_merge_n_cache.sv | 185 ++++++++++++++++++
 tb/tb_arb_merge_n_cache.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_merge_n_cache.sv
`default_nettype none
// ============================================================================
// Module   : arb_merge_n_cache
// Brief    : N-channel merge. Each input channel feeds its own small FIFO.
//            An arbiter pops one non-empty FIFO per load into a single output
//            register stage that supports full-throughput pass-through.
// Config   : ARB_MERGE_N_RR_EN defined   -> round-robin arbitration
//            ARB_MERGE_N_RR_EN undefined -> fixed priority (lowest index wins)
// Revision : 1.0 - initial release
// ============================================================================
module arb_merge_n_cache #(
  parameter int DATA_WIDTH = 5,
  parameter int CH_NUM     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [CH_NUM-1:0]                          i_drive,
  input  logic [CH_NUM*DATA_WIDTH-1:0]               i_data,
  output logic [CH_NUM-1:0]                          o_free,
  output logic                                       o_driveNext,
  output logic [DATA_WIDTH-1:0]                      o_data,
  output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] o_grantId,
  input  logic                                       i_freeNext
);

  localparam int GRANT_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Per-channel FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem       [CH_NUM][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr    [CH_NUM];
  logic [PTR_W-1:0]      rd_ptr    [CH_NUM];
  logic [CNT_W-1:0]      count     [CH_NUM];
  logic [CNT_W-1:0]      count_nxt [CH_NUM];
  logic [CH_NUM-1:0]     free_q;
  logic [CH_NUM-1:0]     push;
  logic [CH_NUM-1:0]     pop;
  logic [CH_NUM-1:0]     nonempty;

  // Arbitration and output stage
  logic                  load_en;
  logic                  grant_valid;
  logic [GRANT_W-1:0]    grant_id;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [GRANT_W-1:0]    out_id;

  // Ready is a registered "not full" flag; it is forced low while reset is
  // held so nothing can be accepted during reset, and comes back high as soon
  // as reset drops so the first edge after release can accept.
  assign o_free      = free_q & {CH_NUM{~rst}};
  assign push        = i_drive & o_free;

  // The output register can take a new word when it is empty or when the
  // word it holds leaves at this same edge.
  assign load_en     = ~out_valid | i_freeNext;

  assign o_driveNext = out_valid;
  assign o_data      = out_data;
  assign o_grantId   = out_id;

  // Occupancy flags and next-state counts for every FIFO
  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      nonempty[k]  = (count[k] != '0);
      count_nxt[k] = count[k]
                   + {{(CNT_W-1){1'b0}}, push[k]}
                   - {{(CNT_W-1){1'b0}}, pop[k]};
    end
  end

  // One-hot pop of the granted FIFO, only on an output load
  always_comb begin
    pop = '0;
    if (load_en && grant_valid) begin
      pop[grant_id] = 1'b1;
    end
  end

  // Head word of the granted FIFO
  always_comb begin
    pop_data = mem[grant_id][rd_ptr[grant_id]];
  end

`ifdef ARB_MERGE_N_RR_EN
  // Last-granted channel; the search starts one past it
  logic [GRANT_W-1:0] rr_ptr;
  // Candidate index, one bit wider so the modulo wrap can be detected
  logic [GRANT_W:0]   rr_idx;

  // Round-robin search: first non-empty FIFO after the last grant, wrapping
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    rr_idx      = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      rr_idx = {1'b0, rr_ptr} + (GRANT_W+1)'(i);
      if (rr_idx >= (GRANT_W+1)'(CH_NUM)) begin
        rr_idx = rr_idx - (GRANT_W+1)'(CH_NUM);
      end
      if (!grant_valid && nonempty[rr_idx[GRANT_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = rr_idx[GRANT_W-1:0];
      end
    end
  end

  // Pointer follows the winner, but only when a word is actually loaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= GRANT_W'(CH_NUM - 1);
    end else if (load_en && grant_valid) begin
      rr_ptr <= grant_id;
    end
  end
`else
  // Fixed priority: lowest-numbered non-empty FIFO wins
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (!grant_valid && nonempty[i]) begin
        grant_valid = 1'b1;
        grant_id    = GRANT_W'(i);
      end
    end
  end
`endif

  // FIFO pointers, counts and the registered not-full flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH_NUM; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
      free_q <= '1;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        if (push[k]) begin
          wr_ptr[k] <= wr_ptr[k] + 1'b1;
        end
        if (pop[k]) begin
          rd_ptr[k] <= rd_ptr[k] + 1'b1;
        end
        count[k]  <= count_nxt[k];
        free_q[k] <= (count_nxt[k] != DEPTH_C);
      end
    end
  end

  // FIFO payload storage; contents need no reset since counts gate reads
  always_ff @(posedge clk) begin
    for (int k = 0; k < CH_NUM; k++) begin
      if (push[k]) begin
        mem[k][wr_ptr[k]] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output register: load the granted word, or go empty if nothing to load.
  // Data and id are held while stalled so downstream sees a stable word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= pop_data;
        out_id    <= grant_id;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arb_merge_n_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_merge_n_cache
// Brief    : Self-checking bench for arb_merge_n_cache. A queue-based
//            reference model predicts o_free / o_driveNext / o_data /
//            o_grantId each cycle; directed scenarios pin literal values.
//            Honours ARB_MERGE_N_RR_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_merge_n_cache;

  localparam int DW    = 5;
  localparam int CH    = 4;
  localparam int DEPTH = 2;
  localparam int GW    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     i_drive;
  logic [CH*DW-1:0]  i_data;
  logic [CH-1:0]     o_free;
  logic              o_driveNext;
  logic [DW-1:0]     o_data;
  logic [GW-1:0]     o_grantId;
  logic              i_freeNext;

  arb_merge_n_cache #(
    .DATA_WIDTH (DW),
    .CH_NUM     (CH),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_drive     (i_drive),
    .i_data      (i_data),
    .o_free      (o_free),
    .o_driveNext (o_driveNext),
    .o_data      (o_data),
    .o_grantId   (o_grantId),
    .i_freeNext  (i_freeNext)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Each channel is a queue of waiting words; the output slot holds one word.
  logic [DW-1:0] mq [CH][$];
  bit            m_valid = 1'b0;
  int            m_data  = 0;
  int            m_id    = 0;
  int            m_last  = CH - 1;
  bit [CH-1:0]   m_free  = '1;
  int            win;
  int            cand;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH; k++) mq[k].delete();
      m_valid = 1'b0;
      m_data  = 0;
      m_id    = 0;
      m_last  = CH - 1;
      m_free  = '1;
    end else begin
      // output slot takes a word when empty or when its word leaves now
      if (!m_valid || i_freeNext) begin
        win = -1;
        for (int j = 0; j < CH; j++) begin
`ifdef ARB_MERGE_N_RR_EN
          cand = (m_last + 1 + j) % CH;
`else
          cand = j;
`endif
          if (win < 0 && mq[cand].size() > 0) win = cand;
        end
        if (win >= 0) begin
          m_data  = int'(mq[win].pop_front());
          m_id    = win;
          m_valid = 1'b1;
          m_last  = win;
        end else begin
          m_valid = 1'b0;
        end
      end
      // accepts use the ready value that was visible before this edge
      for (int k = 0; k < CH; k++)
        if (i_drive[k] && m_free[k]) mq[k].push_back(i_data[k*DW +: DW]);
      for (int k = 0; k < CH; k++)
        m_free[k] = (mq[k].size() < DEPTH);
    end
  end

  // ---------------- per-cycle compare ----------------
  bit prev_stall = 1'b0;
  int prev_data  = 0;
  int prev_id    = 0;

  always @(negedge clk) begin
    chk("o_free", int'(o_free), rst ? 0 : int'(m_free));
    chk("o_driveNext", int'(o_driveNext), int'(m_valid));
    if (m_valid) begin
      chk("o_data", int'(o_data), m_data);
      chk("o_grantId", int'(o_grantId), m_id);
    end
    if (prev_stall && !rst) begin
      chk("stall_hold_data", int'(o_data), prev_data);
      chk("stall_hold_id", int'(o_grantId), prev_id);
    end
    prev_stall = !rst && o_driveNext && !i_freeNext;
    prev_data  = int'(o_data);
    prev_id    = int'(o_grantId);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input int v);
    i_data[k*DW +: DW] = DW'(v);
  endtask

  task automatic do_reset();
    i_drive    = '0;
    i_freeNext = 1'b0;
    rst        = 1'b1;
    step();
    step();
    rst        = 1'b0;
  endtask

  int seq [CH];
  logic [CH-1:0] acc;

  initial begin
    rst        = 1'b1;
    i_drive    = '0;
    i_data     = '0;
    i_freeNext = 1'b0;
    step();
    step();
    // reset state
    chk("rst_o_free", int'(o_free), 0);
    chk("rst_driveNext", int'(o_driveNext), 0);
    chk("rst_o_data", int'(o_data), 0);
    chk("rst_grantId", int'(o_grantId), 0);
    rst = 1'b0;
    #1;
    chk("release_o_free", int'(o_free), 4'hF);

    // single word 0x15 on channel 2: two-edge latency
    set_ch(2, 'h15);
    i_drive    = 4'b0100;
    i_freeNext = 1'b1;
    step();
    i_drive = '0;
    chk("lat_not_yet", int'(o_driveNext), 0);
    step();
    chk("lat_valid", int'(o_driveNext), 1);
    chk("lat_data", int'(o_data), 'h15);
    chk("lat_grant", int'(o_grantId), 2);
    step();
    chk("lat_drained", int'(o_driveNext), 0);

    // all four channels push together: grants 0,1,2,3
    do_reset();
    i_freeNext = 1'b1;
    for (int k = 0; k < CH; k++) set_ch(k, 8 + k);
    i_drive = '1;
    step();
    i_drive = '0;
    for (int g = 0; g < CH; g++) begin
      step();
      chk("all4_grant", int'(o_grantId), g);
      chk("all4_data", int'(o_data), 8 + g);
    end
    step();
    chk("all4_drained", int'(o_driveNext), 0);

    // ch0 and ch3 continuously valid
    do_reset();
    i_freeNext = 1'b1;
    i_drive    = 4'b1001;
    set_ch(0, 0);
    set_ch(3, 16);
    for (int c = 0; c < 8; c++) begin
      step();
      set_ch(0, c + 1);
      set_ch(3, 17 + c);
      if (c >= 1) begin
`ifdef ARB_MERGE_N_RR_EN
        chk("pair_grant_rr", int'(o_grantId), ((c - 1) % 2 == 0) ? 0 : 3);
`else
        chk("pair_grant_fixed", int'(o_grantId), 0);
        if (c >= 2) chk("pair_ch3_full", int'(o_free[3]), 0);
`endif
      end
    end
    i_drive = '0;

    // depth-2 overflow with output stalled
    do_reset();
    i_freeNext = 1'b0;
    i_drive    = 4'b0010;
    set_ch(1, 1);
    step();
    set_ch(1, 2);
    step();
    set_ch(1, 3);
    step();
    chk("ovf_free1", int'(o_free[1]), 0);
    set_ch(1, 4);
    step();
    chk("ovf_hold_valid", int'(o_driveNext), 1);
    chk("ovf_hold_data", int'(o_data), 1);
    i_drive    = '0;
    i_freeNext = 1'b1;
    step();
    chk("ovf_data2", int'(o_data), 2);
    step();
    chk("ovf_data3", int'(o_data), 3);
    step();
    chk("ovf_drained", int'(o_driveNext), 0);

    // reset mid-burst with three words in flight
    do_reset();
    i_freeNext = 1'b0;
    i_drive    = 4'b0111;
    set_ch(0, 5);
    set_ch(1, 6);
    set_ch(2, 7);
    step();
    i_drive = '0;
    step();
    chk("burst_valid", int'(o_driveNext), 1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", int'(o_driveNext), 0);
    chk("midrst_data", int'(o_data), 0);
    chk("midrst_grant", int'(o_grantId), 0);
    chk("midrst_free", int'(o_free), 0);
    step();
    step();
    rst        = 1'b0;
    i_freeNext = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("midrst_flushed", int'(o_driveNext), 0);
    end

    // saturated channels with sequence numbers, downstream toggling
    do_reset();
    for (int k = 0; k < CH; k++) begin
      seq[k] = 0;
      set_ch(k, 0);
    end
    i_drive = '1;
    for (int c = 0; c < 300; c++) begin
      i_freeNext = c[0];
      acc = i_drive & o_free;
      step();
      for (int k = 0; k < CH; k++) begin
        if (acc[k]) seq[k] = seq[k] + 1;
        set_ch(k, seq[k]);
      end
    end

    // randomized traffic with occasional resets
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      i_drive    = CH'($urandom);
      i_data     = (CH*DW)'($urandom);
      i_freeNext = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      step();
    end

    // drain
    i_drive    = '0;
    i_freeNext = 1'b1;
    repeat (12) step();
    chk("final_drained", int'(o_driveNext), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
